// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the ALU op sequencer
// ALU op codes, FSM states and the buffered command layout
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_INC = 3'd3,
    ALU_ADD = 3'd4,
    ALU_SUB = 3'd5,
    ALU_SLT = 3'd6,
    ALU_SLL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    alu_op_e    op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wb;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/seq_cmd_fifo.sv
// seq_cmd_fifo: synchronous command buffer
// Pointers carry a wrap bit so full/empty need no counter
module seq_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic Reset,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t           mem [DEPTH];
  logic [AW:0]    wp;
  logic [AW:0]    rp;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata   = mem[rp[AW-1:0]];

  // pointer update; cleared by reset to flush the buffer
  always_ff @(posedge clk) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives regfile+ALU datapath from commands
// read -> ALU -> optional writeback -> response, one state/cycle
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter bit OF_SUPPRESS_WB = 1'b0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_rs,
  input  logic [4:0]       cmd_rt,
  input  logic [4:0]       cmd_rd,
  input  logic             cmd_wb,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       R_Addr_B,
  output logic [4:0]       W_Addr,
  output logic [2:0]       ALU_OP,
  output logic             Write_Reg,
  input  logic [31:0]      F,
  input  logic             OF,
  input  logic             ZF,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_of,
  output logic             rsp_zf,
  output logic             rsp_wrote,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  seq_state_e state_q;
  seq_state_e state_d;
  cmd_t       cur_q;
  cmd_t       head;
  cmd_t       in_cmd;
  logic       fifo_pop;
  logic       full;
  logic       empty;
  logic       wb_go;

  assign in_cmd = '{op: alu_op_e'(cmd_op), rs: cmd_rs,
                    rt: cmd_rt, rd: cmd_rd, wb: cmd_wb};

  seq_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .push  (cmd_valid),
    .wdata (in_cmd),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign R_Addr_A  = cur_q.rs;
  assign R_Addr_B  = cur_q.rt;
  assign W_Addr    = cur_q.rd;
  assign ALU_OP    = cur_q.op;
  assign wb_go     = cur_q.wb && !(OF_SUPPRESS_WB && OF);

  // state register
  always_ff @(posedge clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state and FIFO pop decision
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          fifo_pop = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = wb_go ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // registered datapath controls, response capture, retire count
  always_ff @(posedge clk) begin
    if (Reset) begin
      cur_q      <= '0;
      Write_Reg  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_of     <= 1'b0;
      rsp_zf     <= 1'b0;
      rsp_wrote  <= 1'b0;
      retired    <= '0;
    end else begin
      if (fifo_pop) cur_q <= head;
      Write_Reg <= (state_d == S_WRITE);
      rsp_valid <= (state_d == S_RESP);
      if (state_q == S_ISSUE) begin
        rsp_result <= F;
        rsp_of     <= OF;
        rsp_zf     <= ZF;
        rsp_wrote  <= wb_go;
      end
      if (state_q == S_RESP && rsp_ready)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with datapath stub
// Command-level reference model predicts every response
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam bit SUPP  = 1'b1;
  localparam int CNT_W = 16;

  logic             clk;
  logic             Reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [4:0]       cmd_rs;
  logic [4:0]       cmd_rt;
  logic [4:0]       cmd_rd;
  logic             cmd_wb;
  logic [4:0]       R_Addr_A;
  logic [4:0]       R_Addr_B;
  logic [4:0]       W_Addr;
  logic [2:0]       ALU_OP;
  logic             Write_Reg;
  logic [31:0]      F;
  logic             OF;
  logic             ZF;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_of;
  logic             rsp_zf;
  logic             rsp_wrote;
  logic             busy;
  logic [CNT_W-1:0] retired;

  alu_op_sequencer #(
    .FIFO_DEPTH     (2),
    .OF_SUPPRESS_WB (SUPP),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_rd     (cmd_rd),
    .cmd_wb     (cmd_wb),
    .R_Addr_A   (R_Addr_A),
    .R_Addr_B   (R_Addr_B),
    .W_Addr     (W_Addr),
    .ALU_OP     (ALU_OP),
    .Write_Reg  (Write_Reg),
    .F          (F),
    .OF         (OF),
    .ZF         (ZF),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_of     (rsp_of),
    .rsp_zf     (rsp_zf),
    .rsp_wrote  (rsp_wrote),
    .busy       (busy),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {of, zf, f}
  function automatic logic [33:0] alu(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] f;
    logic        of;
    f  = 32'd0;
    of = 1'b0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: begin
        f  = a + 32'd1;
        of = (a == 32'h7FFF_FFFF);
      end
      3'd4: begin
        f  = a + b;
        of = (a[31] == b[31]) && (f[31] != a[31]);
      end
      3'd5: begin
        f  = a - b;
        of = (a[31] != b[31]) && (f[31] != a[31]);
      end
      3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: f = b << a[4:0];
    endcase
    return {of, (f == 32'd0), f};
  endfunction

  // datapath stub: register file + combinational ALU
  logic [31:0] rf [32];
  assign {OF, ZF, F} = alu(ALU_OP, rf[R_Addr_A], rf[R_Addr_B]);

  always @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (Write_Reg) begin
      rf[W_Addr] <= F;
    end
  end

  typedef struct {
    logic [31:0] res;
    logic        of;
    logic        zf;
    logic        wrote;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q [$];
  logic [31:0] rr [32];
  int          errors = 0;
  int          checks = 0;
  int          n_cmds = 0;
  int          exp_ret = 0;
  int          wr_cnt = 0;
  logic [4:0]  last_wa = 5'd0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // monitor: count write pulses, pop and compare each response
  always @(negedge clk) begin
    exp_t e;
    if (Reset) begin
      exp_ret = 0;
      wr_cnt  = 0;
    end else begin
      if (Write_Reg) begin
        wr_cnt++;
        last_wa = W_Addr;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %h expected none",
                   rsp_result);
        end else begin
          e = q.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_of", 32'(rsp_of), 32'(e.of));
          chk("rsp_zf", 32'(rsp_zf), 32'(e.zf));
          chk("rsp_wrote", 32'(rsp_wrote), 32'(e.wrote));
          chk("write_pulses", wr_cnt, 32'(e.wrote));
          if (e.wrote) chk("w_addr", 32'(last_wa), 32'(e.rd));
          chk("retired", 32'(retired), exp_ret & 32'hFFFF);
          exp_ret++;
        end
        wr_cnt = 0;
      end
    end
  end

  // random consumer back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic push(input logic [2:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic wb);
    int          t;
    logic [33:0] r;
    exp_t        e;
    t = 0;
    cmd_op = op;
    cmd_rs = rs;
    cmd_rt = rt;
    cmd_rd = rd;
    cmd_wb = wb;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got cmd_ready=0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    r       = alu(op, rr[rs], rr[rt]);
    e.res   = r[31:0];
    e.zf    = r[32];
    e.of    = r[33];
    e.wrote = wb && !(SUPP && r[33]);
    e.rd    = rd;
    if (e.wrote) rr[rd] = r[31:0];
    q.push_back(e);
    n_cmds++;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((q.size() != 0 || busy || rsp_valid) && t < 3000);
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
    end
  endtask

  // negedges from accept until rsp_valid is seen
  task automatic lat(input int exp_n, input logic [31:0] exp_res);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    chk("latency", n, exp_n);
    chk("lat_result", rsp_result, exp_res);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 Reset = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) rr[i] = 32'd0;
    n_cmds = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          t;
    Reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_rs = 5'd0;
    cmd_rt = 5'd0;
    cmd_rd = 5'd0;
    cmd_wb = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) rr[i] = 32'd0;
    do_reset();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_write_reg", 32'(Write_Reg), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_addr", {17'd0, R_Addr_A, R_Addr_B, W_Addr},
        32'd0);

    push(3'd3, 5'd0, 5'd0, 5'd1, 1'b1);
    lat(4, 32'd1);
    wait_idle();

    push(3'd4, 5'd1, 5'd1, 5'd2, 1'b1);
    push(3'd7, 5'd1, 5'd2, 5'd3, 1'b1);
    wait_idle();
    chk("r3_value", rf[3], 32'd4);

    push(3'd5, 5'd0, 5'd1, 5'd4, 1'b1);
    lat(4, 32'hFFFF_FFFF);
    wait_idle();
    push(3'd2, 5'd1, 5'd1, 5'd8, 1'b0);
    lat(3, 32'd0);
    wait_idle();
    chk("r8_untouched", rf[8], 32'd0);

    rsp_ready = 1'b0;
    push(3'd4, 5'd2, 5'd3, 5'd10, 1'b1);
    push(3'd1, 5'd4, 5'd1, 5'd11, 1'b1);
    push(3'd6, 5'd4, 5'd1, 5'd12, 1'b1);
    repeat (3) @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("held_valid", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("held_result", rsp_result, q[0].res);
    chk("held_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    wait_idle();
    chk("retired_total", 32'(retired), n_cmds & 32'hFFFF);

    push(3'd3, 5'd4, 5'd0, 5'd9, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!Write_Reg && t < 20);
    chk("saw_write", 32'(Write_Reg), 32'd1);
    do_reset();
    @(negedge clk);
    chk("abort_write_reg", 32'(Write_Reg), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    push(3'd1, 5'd9, 5'd9, 5'd0, 1'b0);
    lat(3, 32'd0);
    wait_idle();

    push(3'd3, 5'd0, 5'd0, 5'd1, 1'b1);
    push(3'd5, 5'd0, 5'd1, 5'd2, 1'b1);
    push(3'd7, 5'd2, 5'd1, 5'd3, 1'b1);
    push(3'd2, 5'd2, 5'd3, 5'd5, 1'b1);
    push(3'd3, 5'd0, 5'd0, 5'd6, 1'b1);
    push(3'd1, 5'd1, 5'd1, 5'd7, 1'b1);
    wait_idle();
    chk("r5_build", rf[5], 32'h7FFF_FFFF);
    push(3'd4, 5'd5, 5'd6, 5'd7, 1'b1);
    lat(3, 32'h8000_0000);
    chk("ovf_of", 32'(rsp_of), 32'd1);
    chk("ovf_wrote", 32'(rsp_wrote), 32'd0);
    wait_idle();
    chk("r7_kept", rf[7], 32'd1);

    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      v = $urandom;
      push(v[2:0], 5'(v[5:3]), 5'(v[8:6]), 5'(v[11:9]), v[12]);
      repeat (v[14:13] == 2'd0 ? 1 : 0) @(posedge clk);
    end
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("final_retired", 32'(retired), n_cmds & 32'hFFFF);
    chk("final_queue", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
